cart_ram_arb: RTL and testbench
===============================

Name: cart_ram_arb

Overview:
- Arbiter/sequencer sharing the 8 KiB cartridge backup RAM between the console CPU bus and the host save-file port.
- The host port is used for battery-save load and store.
- The CPU always has priority and is never stalled. Host accesses use idle RAM cycles and are acknowledged by a one-cycle pulse.
- Tracks a dirty flag so the host knows when a save-file write-back is needed.

Parameters:
AW, 13, RAM address width (8 KiB)
DW, 8, RAM data width

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
CPU_A  in  AW  CPU address
CPU_DI  in  DW  CPU write data
CPU_DO  out  DW  CPU read data
CPU_nCE  in  1  CPU chip enable, active low
CPU_nWE  in  1  CPU write enable, active low
CPU_nOE  in  1  CPU output enable, active low
WP  in  1  write protect; blocks CPU writes only
HOST_REQ  in  1  host request, held until HOST_ACK
HOST_WR  in  1  1=write, 0=read; stable while HOST_REQ
HOST_A  in  AW  host address
HOST_DI  in  DW  host write data
HOST_DO  out  DW  host read data, valid with HOST_ACK
HOST_ACK  out  1  one-cycle completion pulse
RAM_A  out  AW  to RAM
RAM_DI  out  DW  to RAM
RAM_DO  in  DW  from RAM; one-cycle read latency, undefined when nCE|nOE
RAM_nCE  out  1  to RAM
RAM_nWE  out  1  to RAM
RAM_nOE  out  1  to RAM
DIRTY  out  1  a CPU write has occurred since the last clear
DIRTY_CLR  in  1  clears DIRTY

Behaviour:
- The interface is one clock (CLK) with a synchronous, active-high reset (RESET).
- Reset:
  - state=IDLE, HOST_ACK=0, HOST_DO=0, DIRTY=0.
  - RAM strobes are driven from the mux, so CPU ownership applies during reset.
  - A host request in flight at reset is dropped; the host must re-request.
- CPU ownership (CPU_nCE=0):
  - RAM_A=CPU_A, RAM_DI=CPU_DI, RAM_nCE=0.
  - RAM_nWE = CPU_nWE | WP.
  - RAM_nOE = CPU_nOE.
  - CPU_DO = RAM_DO, combinational pass-through.
  - Zero added latency; the CPU sees the RAM's native one-cycle read latency.
- Host ownership: only in cycles with CPU_nCE=1.
  - The mux selects host signals when state is H_WR, H_RD or H_DATA.
  - Otherwise RAM_nCE=1, RAM_nWE=1, RAM_nOE=1.
- FSM:
  - IDLE: if HOST_REQ and CPU_nCE=1:
    - HOST_WR=1 -> H_WR.
    - HOST_WR=0 -> H_RD.
  - Entry is registered, so the first host RAM cycle is the cycle after the decision.
  - H_WR: if CPU_nCE=1, drive RAM_nCE=0, RAM_nWE=0, RAM_A=HOST_A, RAM_DI=HOST_DI, then -> ACK. Otherwise stay in H_WR (retry).
  - H_RD: if CPU_nCE=1, drive RAM_nCE=0, RAM_nOE=0, RAM_A=HOST_A, then -> H_DATA. Otherwise stay in H_RD.
  - H_DATA: if CPU_nCE=1, keep RAM_nCE=0, RAM_nOE=0, RAM_A=HOST_A, capture HOST_DO<=RAM_DO, then -> ACK. If CPU_nCE=0, the CPU takes the RAM, the sample is discarded, and the state goes back to H_RD.
  - ACK: HOST_ACK=1 for exactly this cycle, then -> IDLE.
- HOST_REQ is ignored while in ACK, so no back-to-back double service. Minimum host write = 3 cycles REQ->ACK; minimum host read = 4 cycles.
- WP never blocks host writes.
- DIRTY:
  - Set in any cycle with CPU_nCE=0, CPU_nWE=0 and WP=0.
  - Host writes do not set it.
  - DIRTY_CLR clears it. If a set and a clear occur in the same cycle, set wins.
- Host starvation is permitted while the CPU holds nCE continuously; there is no timeout.

Decomposition:
- Shared package scv_pkg holds the arbiter state enum (IDLE, H_WR, H_RD, H_DATA, ACK) and the constant CART_RAM_AW=13.
- No sub-module. Only cart_ram is instantiated beside this block, at the top level.

Test Plan:
- Host write then read:
  - Stimulus: CPU idle; host writes 0x5A to 0x0123, then reads 0x0123.
  - Response: write ACK 3 cycles after REQ; read ACK 4 cycles after REQ with HOST_DO=0x5A; DIRTY stays 0.
- CPU write with protect:
  - Stimulus: CPU writes 0xA5 to 0x1FFF with WP=0, then 0x11 to 0x1FFF with WP=1, then a CPU read.
  - Response: CPU_DO=0xA5 one cycle after the read; DIRTY=1 after the first write only.
- CPU preempts a host read:
  - Stimulus: host read of 0x0010 issued; CPU_nCE falls during H_DATA for 2 cycles.
  - Response: state returns to H_RD; RAM_A follows CPU_A during those cycles; ACK arrives after the retry with the correct byte; exactly one ACK pulse.
- DIRTY set/clear race:
  - Stimulus: DIRTY_CLR in the same cycle as a CPU write.
  - Response: DIRTY=1.
  - Stimulus: DIRTY_CLR alone.
  - Response: DIRTY=0 next cycle.
- Reset mid-operation:
  - Stimulus: RESET asserted in H_RD.
  - Response: state=IDLE, HOST_ACK=0, DIRTY=0 next cycle; no ACK until the host re-requests.
- Host starvation:
  - Stimulus: CPU_nCE held low for 100 cycles with HOST_REQ=1.
  - Response: no ACK and no host strobe on RAM during those cycles; ACK within 4 cycles after CPU_nCE rises.

Source files
------------

// File: rtl/scv_pkg.sv
// Shared definitions for the cartridge backup RAM arbiter.
package scv_pkg;

    localparam int unsigned CART_RAM_AW = 13;
    localparam int unsigned CART_RAM_DW = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        H_WR   = 3'd1,
        H_RD   = 3'd2,
        H_DATA = 3'd3,
        ACK    = 3'd4
    } arb_state_t;

endpackage

// File: rtl/cart_ram_arb.sv
// Shares the cartridge backup RAM between the CPU bus (always first) and the
// host save-file port, which only gets RAM cycles the CPU leaves idle.
module cart_ram_arb
    import scv_pkg::*;
#(
    parameter int unsigned AW = CART_RAM_AW,
    parameter int unsigned DW = CART_RAM_DW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [AW-1:0] CPU_A,
    input  logic [DW-1:0] CPU_DI,
    output logic [DW-1:0] CPU_DO,
    input  logic          CPU_nCE,
    input  logic          CPU_nWE,
    input  logic          CPU_nOE,
    input  logic          WP,
    input  logic          HOST_REQ,
    input  logic          HOST_WR,
    input  logic [AW-1:0] HOST_A,
    input  logic [DW-1:0] HOST_DI,
    output logic [DW-1:0] HOST_DO,
    output logic          HOST_ACK,
    output logic [AW-1:0] RAM_A,
    output logic [DW-1:0] RAM_DI,
    input  logic [DW-1:0] RAM_DO,
    output logic          RAM_nCE,
    output logic          RAM_nWE,
    output logic          RAM_nOE,
    output logic          DIRTY,
    input  logic          DIRTY_CLR
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       host_sel;
    logic       host_we;
    logic       host_oe;
    logic       cpu_free;
    logic       cpu_wr;

    assign cpu_free = CPU_nCE;
    assign cpu_wr   = ~CPU_nCE & ~CPU_nWE & ~WP;
    assign CPU_DO   = RAM_DO;

    // Host sequencer: every host RAM cycle needs the CPU to be deselected.
    always_comb begin
        state_d  = state_q;
        host_sel = 1'b0;
        host_we  = 1'b0;
        host_oe  = 1'b0;
        case (state_q)
            IDLE: begin
                if (HOST_REQ && cpu_free) begin
                    state_d = HOST_WR ? H_WR : H_RD;
                end
            end
            H_WR: begin
                host_sel = 1'b1;
                host_we  = 1'b1;
                if (cpu_free) begin
                    state_d = ACK;
                end
            end
            H_RD: begin
                host_sel = 1'b1;
                host_oe  = 1'b1;
                if (cpu_free) begin
                    state_d = H_DATA;
                end
            end
            H_DATA: begin
                host_sel = 1'b1;
                host_oe  = 1'b1;
                // A CPU access here spoils the pending read; reissue it.
                state_d  = cpu_free ? ACK : H_RD;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM mux: the CPU wins any cycle it selects the chip.
    always_comb begin
        RAM_A   = CPU_A;
        RAM_DI  = CPU_DI;
        RAM_nCE = 1'b1;
        RAM_nWE = 1'b1;
        RAM_nOE = 1'b1;
        if (!CPU_nCE) begin
            RAM_nCE = 1'b0;
            RAM_nWE = CPU_nWE | WP;
            RAM_nOE = CPU_nOE;
        end else if (host_sel) begin
            RAM_A   = HOST_A;
            RAM_DI  = HOST_DI;
            RAM_nCE = 1'b0;
            RAM_nWE = ~host_we;
            RAM_nOE = ~host_oe;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            HOST_ACK <= 1'b0;
            HOST_DO  <= '0;
        end else begin
            state_q  <= state_d;
            HOST_ACK <= (state_d == ACK);
            if (state_q == H_DATA && cpu_free) begin
                HOST_DO <= RAM_DO;
            end
        end
    end

    // Set beats clear so a CPU write racing DIRTY_CLR is never lost.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            DIRTY <= 1'b0;
        end else if (cpu_wr) begin
            DIRTY <= 1'b1;
        end else if (DIRTY_CLR) begin
            DIRTY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cart_ram_arb.sv
// Bench for cart_ram_arb: directed scenarios plus randomized CPU/host traffic
// against a cycle-level reference of the arbitration rules and RAM contents.
module tb_cart_ram_arb;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [AW-1:0] CPU_A;
    logic [DW-1:0] CPU_DI;
    logic [DW-1:0] CPU_DO;
    logic          CPU_nCE, CPU_nWE, CPU_nOE, WP;
    logic          HOST_REQ, HOST_WR;
    logic [AW-1:0] HOST_A;
    logic [DW-1:0] HOST_DI;
    logic [DW-1:0] HOST_DO;
    logic          HOST_ACK;
    logic [AW-1:0] RAM_A;
    logic [DW-1:0] RAM_DI;
    logic [DW-1:0] RAM_DO;
    logic          RAM_nCE, RAM_nWE, RAM_nOE;
    logic          DIRTY, DIRTY_CLR;

    cart_ram_arb #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_A(CPU_A), .CPU_DI(CPU_DI), .CPU_DO(CPU_DO),
        .CPU_nCE(CPU_nCE), .CPU_nWE(CPU_nWE), .CPU_nOE(CPU_nOE), .WP(WP),
        .HOST_REQ(HOST_REQ), .HOST_WR(HOST_WR), .HOST_A(HOST_A),
        .HOST_DI(HOST_DI), .HOST_DO(HOST_DO), .HOST_ACK(HOST_ACK),
        .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO),
        .RAM_nCE(RAM_nCE), .RAM_nWE(RAM_nWE), .RAM_nOE(RAM_nOE),
        .DIRTY(DIRTY), .DIRTY_CLR(DIRTY_CLR)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM with one-cycle read latency; junk when not reading.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge CLK) begin
        if (!RAM_nCE && !RAM_nOE) RAM_DO <= mem[RAM_A];
        else                      RAM_DO <= DW'($urandom);
        if (!RAM_nCE && !RAM_nWE) mem[RAM_A] = RAM_DI;
    end

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [DW-1:0] ref_mem [DEPTH];
    logic          m_ack = 1'b0, m_dirty = 1'b0, m_acc = 1'b0, m_wr = 1'b0;
    logic [DW-1:0] m_hdo = '0, m_d = '0, m_rd_exp = '0;
    logic [AW-1:0] m_a = '0;
    logic          m_rd_chk = 1'b0;
    int            m_free = 0;

    logic          saw_ack, last_dirty;
    logic [DW-1:0] last_cpu_do, last_hdo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_idle();
        CPU_nCE = 1'b1; CPU_nWE = 1'b1; CPU_nOE = 1'b1; WP = 1'b0; DIRTY_CLR = 1'b0;
    endtask

    task automatic cpu_rand(input int busy_pct);
        if (int'($urandom_range(99)) < busy_pct) begin
            CPU_nCE = 1'b0;
            CPU_A   = AW'($urandom_range(63));
            CPU_DI  = DW'($urandom);
            WP      = 1'($urandom_range(1));
            if ($urandom_range(1) == 1) begin
                CPU_nWE = 1'b0; CPU_nOE = 1'b1;
            end else begin
                CPU_nWE = 1'b1; CPU_nOE = 1'b0;
            end
        end else begin
            cpu_idle();
        end
        DIRTY_CLR = ($urandom_range(7) == 0);
    endtask

    // One clock: check outputs mid-cycle, then advance the reference.
    task automatic tick();
        logic cpu_free;
        @(negedge CLK);
        saw_ack = HOST_ACK; last_cpu_do = CPU_DO; last_dirty = DIRTY; last_hdo = HOST_DO;
        chk("host_ack", 32'(HOST_ACK), 32'(m_ack));
        chk("host_do", 32'(HOST_DO), 32'(m_hdo));
        chk("dirty", 32'(DIRTY), 32'(m_dirty));
        if (m_rd_chk) chk("cpu_do", 32'(CPU_DO), 32'(m_rd_exp));
        cpu_free = CPU_nCE;
        if (!cpu_free) begin
            chk("ram_a_cpu", 32'(RAM_A), 32'(CPU_A));
            chk("ram_strb_cpu", 32'({RAM_nCE, RAM_nWE, RAM_nOE}), 32'({1'b0, CPU_nWE | WP, CPU_nOE}));
            if (!CPU_nWE) chk("ram_di_cpu", 32'(RAM_DI), 32'(CPU_DI));
        end else if (m_acc) begin
            chk("ram_a_host", 32'(RAM_A), 32'(m_a));
            chk("ram_strb_host", 32'({RAM_nCE, RAM_nWE, RAM_nOE}), m_wr ? 32'h1 : 32'h2);
            if (m_wr) chk("ram_di_host", 32'(RAM_DI), 32'(m_d));
        end else begin
            chk("ram_strb_idle", 32'({RAM_nCE, RAM_nWE, RAM_nOE}), 32'h7);
        end

        m_rd_chk = !CPU_nCE && !CPU_nOE && CPU_nWE;
        m_rd_exp = ref_mem[CPU_A];
        if (!CPU_nCE && !CPU_nWE && !WP) ref_mem[CPU_A] = CPU_DI;
        if (RESET) begin
            m_acc = 1'b0; m_ack = 1'b0; m_hdo = '0; m_dirty = 1'b0;
        end else begin
            if (!CPU_nCE && !CPU_nWE && !WP) m_dirty = 1'b1;
            else if (DIRTY_CLR)              m_dirty = 1'b0;
            if (m_ack) begin
                m_ack = 1'b0;
            end else if (!m_acc) begin
                if (HOST_REQ && cpu_free) begin
                    m_acc = 1'b1; m_free = 0; m_wr = HOST_WR; m_a = HOST_A; m_d = HOST_DI;
                end
            end else begin
                // Writes need one free cycle; reads need two in a row.
                m_free = cpu_free ? m_free + 1 : 0;
                if (m_wr && m_free == 1) begin
                    ref_mem[m_a] = m_d; m_acc = 1'b0; m_ack = 1'b1;
                end else if (!m_wr && m_free == 2) begin
                    m_hdo = ref_mem[m_a]; m_acc = 1'b0; m_ack = 1'b1;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic host_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int busy_pct, output int lat);
        HOST_REQ = 1'b1; HOST_WR = wr; HOST_A = a; HOST_DI = d;
        lat = 0;
        do begin
            if (busy_pct > 0) cpu_rand(busy_pct);
            tick();
            lat++;
        end while (!saw_ack && lat < 400);
        chk("host_timeout", 32'(saw_ack), 32'h1);
        HOST_REQ = 1'b0;
        cpu_idle();
    endtask

    initial begin
        int lat, acks;
        logic [DW-1:0] v;
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = DW'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        RESET = 1'b1; HOST_REQ = 1'b0; HOST_WR = 1'b0; HOST_A = '0; HOST_DI = '0;
        CPU_A = '0; CPU_DI = '0;
        cpu_idle();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ack", 32'(HOST_ACK), 32'h0);
        chk("rst_hdo", 32'(HOST_DO), 32'h0);
        chk("rst_dirty", 32'(DIRTY), 32'h0);
        RESET = 1'b0;
        tick();

        // Host write then read with CPU idle
        host_op(1'b1, 13'h0123, 8'h5A, 0, lat);
        chk("wr_lat", 32'(lat), 32'd3);
        host_op(1'b0, 13'h0123, 8'h00, 0, lat);
        chk("rd_lat", 32'(lat), 32'd4);
        chk("rd_data", 32'(HOST_DO), 32'h5A);
        chk("rd_dirty", 32'(DIRTY), 32'h0);

        // CPU writes, the second blocked by WP, then a read back
        CPU_nCE = 1'b0; CPU_nWE = 1'b0; CPU_nOE = 1'b1; CPU_A = 13'h1FFF; CPU_DI = 8'hA5; WP = 1'b0;
        tick();
        CPU_DI = 8'h11; WP = 1'b1;
        tick();
        chk("dirty_after_wr", 32'(last_dirty), 32'h1);
        CPU_nWE = 1'b1; CPU_nOE = 1'b0; WP = 1'b0;
        tick();
        cpu_idle();
        tick();
        chk("cpu_rd_wp", 32'(last_cpu_do), 32'hA5);

        // CPU preempts a host read in its data cycle
        host_op(1'b1, 13'h0010, 8'hC3, 0, lat);
        HOST_REQ = 1'b1; HOST_WR = 1'b0; HOST_A = 13'h0010;
        tick(); tick();
        lat = 2; acks = 0;
        for (int i = 0; i < 2; i++) begin
            CPU_nCE = 1'b0; CPU_nOE = 1'b0; CPU_nWE = 1'b1; CPU_A = 13'h0200 + AW'(i);
            tick();
            lat++; acks += int'(saw_ack);
        end
        cpu_idle();
        while (!saw_ack && lat < 50) begin
            tick();
            lat++; acks += int'(saw_ack);
        end
        HOST_REQ = 1'b0;
        chk("preempt_lat", 32'(lat), 32'd7);
        chk("preempt_data", 32'(HOST_DO), 32'hC3);
        repeat (3) begin
            tick();
            acks += int'(saw_ack);
        end
        chk("preempt_acks", 32'(acks), 32'd1);

        // DIRTY set/clear race, then clear alone
        CPU_nCE = 1'b0; CPU_nWE = 1'b0; CPU_nOE = 1'b1; CPU_A = 13'h0400; CPU_DI = 8'h77; DIRTY_CLR = 1'b1;
        tick();
        cpu_idle();
        tick();
        chk("race_dirty", 32'(last_dirty), 32'h1);
        DIRTY_CLR = 1'b1;
        tick();
        DIRTY_CLR = 1'b0;
        tick();
        chk("clr_dirty", 32'(last_dirty), 32'h0);

        // Host starvation while the CPU holds the chip
        HOST_REQ = 1'b1; HOST_WR = 1'b0; HOST_A = 13'h0123;
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            CPU_nCE = 1'b0; CPU_nWE = 1'b1; CPU_nOE = 1'b0; CPU_A = AW'($urandom);
            tick();
            acks += int'(saw_ack);
        end
        chk("starve_acks", 32'(acks), 32'd0);
        cpu_idle();
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!saw_ack && lat < 20);
        HOST_REQ = 1'b0;
        chk("starve_lat", 32'(lat), 32'd4);
        chk("starve_data", 32'(HOST_DO), 32'h5A);

        // Reset while a host read sits in H_RD
        CPU_nCE = 1'b0; CPU_nWE = 1'b0; CPU_nOE = 1'b1; CPU_A = 13'h0401; CPU_DI = 8'h3C;
        tick();
        cpu_idle();
        HOST_REQ = 1'b1; HOST_WR = 1'b0; HOST_A = 13'h0123;
        tick();
        RESET = 1'b1; HOST_REQ = 1'b0;
        tick();
        RESET = 1'b0;
        tick();
        chk("mid_rst_ack", 32'(saw_ack), 32'h0);
        chk("mid_rst_dirty", 32'(last_dirty), 32'h0);
        chk("mid_rst_hdo", 32'(last_hdo), 32'h0);
        acks = 0;
        repeat (5) begin
            tick();
            acks += int'(saw_ack);
        end
        chk("mid_rst_noack", 32'(acks), 32'd0);
        host_op(1'b0, 13'h0123, 8'h00, 0, lat);
        chk("rerq_lat", 32'(lat), 32'd4);
        chk("rerq_data", 32'(HOST_DO), 32'h5A);

        // Randomized host traffic under random CPU interference
        for (int n = 0; n < 80; n++) begin
            host_op(1'($urandom_range(1)), AW'($urandom_range(63)), DW'($urandom), 45, lat);
            repeat ($urandom_range(3)) begin
                cpu_rand(60);
                tick();
            end
            cpu_idle();
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
